wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  MEM/WB pipeline register plus write-back datapath of the DLX MIPS-Lite pipe.
//  Latches the instruction leaving MEM with its ALU result, load data and link value.
//  Decodes destination register and write-back source, aligns sub-word loads and
//  drives the register-file write port. Also provides a one-cycle write bypass and a retire counter.
// PARAMETERS
//  DW      32      datapath width
//  CNT_W   32      retire counter width
//  NOP_IR  32'h0   instruction word inserted on reset/flush (bubble)
// PORTS
//  CLK        in   1    clock; all state on posedge
//  reset      in   1    asynchronous, active-high reset
//  MEM_IR     in   32   instruction leaving MEM
//  MEM_valid  in   1    MEM_IR is a real instruction
//  MEM_ALUout in   DW   ALU result / effective address
//  MEM_LMD    in   DW   raw word read from data cache
//  MEM_link   in   DW   link value for JAL/JALR
//  WB_stall   in   1    hold WB register; no RF write this cycle
//  WB_flush   in   1    capture a bubble instead of MEM contents
//  WB_IR      out  32   instruction currently in WB
//  WB_valid   out  1    WB holds a real instruction
//  RF_we      out  1    register-file write enable
//  RF_waddr   out  5    register-file write address
//  RF_wdata   out  DW   register-file write data
//  BYP_valid  out  1    previous cycle performed an RF write
//  BYP_addr   out  5    address of that write
//  BYP_data   out  DW   data of that write
//  RETIRE_CNT out  CNT_W instructions retired since reset
// BEHAVIOUR
//  Reset (async): WB_IR=NOP_IR, WB_valid=0, ALU/LMD/link regs=0, BYP_valid=0,
//   BYP_addr=0, BYP_data=0, RETIRE_CNT=0; hence RF_we=0.
//  Capture on posedge: WB_flush -> bubble (IR=NOP_IR, valid=0); else WB_stall ->
//   hold all; else load MEM_* fields. Flush dominates stall.
//  Latency: RF write occurs in the cycle after MEM presents the instruction.
//  Dest decode (combinational from WB_IR): SPECIAL R-type -> rd; JAL -> 31;
//   I-type ALU and loads -> rt; stores, branches, J, JR, NOP -> 0.
//  WB source select: loads -> aligned load data; JAL, SPECIAL/JALR -> link;
//   everything else -> ALU result.
//  Load align, big-endian, offset = ALU[1:0]: LW whole word; LH/LHU half
//   (offset 0 -> [31:16], 2 -> [15:0]); LB/LBU byte (0 -> [31:24] .. 3 -> [7:0]);
//   LB/LH sign-extend, LBU/LHU zero-extend. Misaligned LH/LW: use offset bits as-is, no trap.
//  RF_we = WB_valid & ~WB_stall & (RF_waddr != 0); writes to r0 are never issued.
//  RF_waddr/RF_wdata are driven from decode even when RF_we=0.
//  Bypass: on each posedge BYP_valid<=RF_we; when RF_we=1, BYP_addr/BYP_data<=RF_waddr/RF_wdata,
//   else they hold their previous value.
//  RETIRE_CNT increments by 1 each cycle WB_valid & ~WB_stall (r0 writes and stores count);
//   saturates at all-ones, never wraps.
//  Stall held across many cycles: exactly one RF write, issued in the cycle stall drops.
//  Reset mid-stall/mid-flush: reset wins immediately; no write is issued after reset.
// STRUCTURE
//  Shared package/defines: opcode and function codes (LW, LH, LHU, LB, LBU, JAL,
//   SPECIAL, JALR), field ranges op/rs/rt/rd/function, WB select encodings
//   load/link/alu, NOP word.
//  One natural sub-module: wb_dest_decode (IR -> 5-bit dest register + 3-bit WB select),
//   purely combinational. Pipeline regs, load aligner, bypass and counter stay in wb_stage.
// TESTING
//  ADD r3 (rd=3), ALUout=0x1234, valid -> next cycle RF_we=1, waddr=3, wdata=0x1234;
//   following cycle BYP_valid=1, BYP_addr=3, BYP_data=0x1234.
//  LB rt=5, ALUout[1:0]=1, LMD=0x12F45678 -> wdata=0xFFFFFFF4; same with LBU -> 0x000000F4;
//   LH offset 2 -> 0x00005678.
//  JAL, link=0x400 -> waddr=31, wdata=0x400; JALR rd=7 -> waddr=7, wdata=link.
//  ADDI rt=0 and SW -> RF_we=0 both, RETIRE_CNT +2.
//  Stall 3 cycles with ADD r4 in WB -> RF_we=0 for 3 cycles, then exactly one write;
//   WB_flush+WB_stall together -> bubble, WB_valid=0.
//  Assert reset mid-stall -> RF_we=0, RETIRE_CNT=0, BYP_valid=0 same cycle;
//   CNT_W=4 run of 20 retires -> RETIRE_CNT stays 15.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: opcode/function codes, IR field ranges and write-back select encodings.
// Rev 1.0
`default_nettype none

package wb_stage_pkg;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FN_MSB    = 5;
  localparam int FN_LSB    = 0;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  typedef enum logic [2:0] {
    WB_SEL_ALU  = 3'b001,
    WB_SEL_LOAD = 3'b010,
    WB_SEL_LINK = 3'b100
  } wb_sel_t;

  // I-type ALU ops occupy opcodes 0x08..0x0F
  function automatic logic is_ialu(input logic [5:0] op);
    return (op[5:3] == 3'b001);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_dest_decode.sv
// wb_dest_decode: WB instruction -> destination register and write-back source.
// Rev 1.0
`default_nettype none

module wb_dest_decode
  import wb_stage_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  dest,
  output wb_sel_t     wb_sel
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_bits;

  assign op          = ir[OP_MSB:OP_LSB];
  assign funct       = ir[FN_MSB:FN_LSB];
  assign rt          = ir[RT_MSB:RT_LSB];
  assign rd          = ir[RD_MSB:RD_LSB];
  assign unused_bits = ^{ir[RS_MSB:RS_LSB], ir[SHAMT_MSB:SHAMT_LSB]};

  always_comb begin
    dest   = 5'd0;
    wb_sel = WB_SEL_ALU;
    case (op)
      OP_SPECIAL: begin
        if (funct != FN_JR) dest = rd;
        if (funct == FN_JALR) wb_sel = WB_SEL_LINK;
      end
      OP_JAL: begin
        dest   = 5'd31;
        wb_sel = WB_SEL_LINK;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        dest   = rt;
        wb_sel = WB_SEL_LOAD;
      end
      default: begin
        if (is_ialu(op)) dest = rt;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, load aligner, RF write port, bypass and retire counter.
// Rev 1.0
`default_nettype none

module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int          DW     = 32,
  parameter int          CNT_W  = 32,
  parameter logic [31:0] NOP_IR = NOP_WORD
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [31:0]      MEM_IR,
  input  logic             MEM_valid,
  input  logic [DW-1:0]    MEM_ALUout,
  input  logic [DW-1:0]    MEM_LMD,
  input  logic [DW-1:0]    MEM_link,
  input  logic             WB_stall,
  input  logic             WB_flush,
  output logic [31:0]      WB_IR,
  output logic             WB_valid,
  output logic             RF_we,
  output logic [4:0]       RF_waddr,
  output logic [DW-1:0]    RF_wdata,
  output logic             BYP_valid,
  output logic [4:0]       BYP_addr,
  output logic [DW-1:0]    BYP_data,
  output logic [CNT_W-1:0] RETIRE_CNT
);

  logic [DW-1:0] alu_reg;
  logic [DW-1:0] lmd_reg;
  logic [DW-1:0] link_reg;
  logic [DW-1:0] load_data;
  logic [4:0]    dest;
  wb_sel_t       wb_sel;
  logic [5:0]    wb_op;
  logic [7:0]    load_byte;
  logic [15:0]   load_half;
  logic          retire;

  wb_dest_decode u_dest_decode (
    .ir     (WB_IR),
    .dest   (dest),
    .wb_sel (wb_sel)
  );

  // Flush has priority over stall so a squashed slot never lingers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      WB_IR    <= NOP_IR;
      WB_valid <= 1'b0;
      alu_reg  <= '0;
      lmd_reg  <= '0;
      link_reg <= '0;
    end else if (WB_flush) begin
      WB_IR    <= NOP_IR;
      WB_valid <= 1'b0;
    end else if (!WB_stall) begin
      WB_IR    <= MEM_IR;
      WB_valid <= MEM_valid;
      alu_reg  <= MEM_ALUout;
      lmd_reg  <= MEM_LMD;
      link_reg <= MEM_link;
    end
  end

  // Big-endian lane pick: offset 0 selects the most significant byte/half.
  assign wb_op     = WB_IR[OP_MSB:OP_LSB];
  assign load_byte = lmd_reg[{~alu_reg[1:0], 3'b000} +: 8];
  assign load_half = lmd_reg[{~alu_reg[1], 4'b0000} +: 16];

  always_comb begin
    load_data = lmd_reg;
    case (wb_op)
      OP_LB:   load_data = {{(DW-8){load_byte[7]}}, load_byte};
      OP_LBU:  load_data = {{(DW-8){1'b0}}, load_byte};
      OP_LH:   load_data = {{(DW-16){load_half[15]}}, load_half};
      OP_LHU:  load_data = {{(DW-16){1'b0}}, load_half};
      default: load_data = lmd_reg;
    endcase
  end

  always_comb begin
    RF_wdata = alu_reg;
    case (wb_sel)
      WB_SEL_LOAD: RF_wdata = load_data;
      WB_SEL_LINK: RF_wdata = link_reg;
      default:     RF_wdata = alu_reg;
    endcase
  end

  assign retire   = WB_valid & ~WB_stall;
  assign RF_waddr = dest;
  assign RF_we    = retire & (dest != 5'd0);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      BYP_valid <= 1'b0;
      BYP_addr  <= 5'd0;
      BYP_data  <= '0;
    end else begin
      BYP_valid <= RF_we;
      if (RF_we) begin
        BYP_addr <= RF_waddr;
        BYP_data <= RF_wdata;
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      RETIRE_CNT <= '0;
    end else if (retire && (RETIRE_CNT != {CNT_W{1'b1}})) begin
      RETIRE_CNT <= RETIRE_CNT + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and randomized checks of wb_stage against a behavioural model.
// Rev 1.0
`default_nettype none

module tb_wb_stage;

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] MEM_IR, MEM_ALUout, MEM_LMD, MEM_link;
  logic        MEM_valid, WB_stall, WB_flush;

  logic [31:0] WB_IR, RF_wdata, BYP_data, RETIRE_CNT;
  logic        WB_valid, RF_we, BYP_valid;
  logic [4:0]  RF_waddr, BYP_addr;

  logic [31:0] s_WB_IR, s_RF_wdata, s_BYP_data;
  logic        s_WB_valid, s_RF_we, s_BYP_valid;
  logic [4:0]  s_RF_waddr, s_BYP_addr;
  logic [3:0]  s_RETIRE_CNT;

  wb_stage #(.DW(32), .CNT_W(32), .NOP_IR(32'h0)) dut (
    .CLK(CLK), .reset(reset), .MEM_IR(MEM_IR), .MEM_valid(MEM_valid),
    .MEM_ALUout(MEM_ALUout), .MEM_LMD(MEM_LMD), .MEM_link(MEM_link),
    .WB_stall(WB_stall), .WB_flush(WB_flush), .WB_IR(WB_IR), .WB_valid(WB_valid),
    .RF_we(RF_we), .RF_waddr(RF_waddr), .RF_wdata(RF_wdata), .BYP_valid(BYP_valid),
    .BYP_addr(BYP_addr), .BYP_data(BYP_data), .RETIRE_CNT(RETIRE_CNT)
  );

  wb_stage #(.DW(32), .CNT_W(4), .NOP_IR(32'h0)) dut4 (
    .CLK(CLK), .reset(reset), .MEM_IR(MEM_IR), .MEM_valid(MEM_valid),
    .MEM_ALUout(MEM_ALUout), .MEM_LMD(MEM_LMD), .MEM_link(MEM_link),
    .WB_stall(WB_stall), .WB_flush(WB_flush), .WB_IR(s_WB_IR), .WB_valid(s_WB_valid),
    .RF_we(s_RF_we), .RF_waddr(s_RF_waddr), .RF_wdata(s_RF_wdata), .BYP_valid(s_BYP_valid),
    .BYP_addr(s_BYP_addr), .BYP_data(s_BYP_data), .RETIRE_CNT(s_RETIRE_CNT)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int wr_count = 0;

  always @(posedge CLK) if (RF_we === 1'b1) wr_count++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state: what the WB slot should hold
  logic [31:0] m_ir, m_alu, m_lmd, m_link, m_byp_data;
  logic        m_valid, m_byp_valid;
  logic [4:0]  m_byp_addr;
  longint      m_cnt;
  int          m_cnt4;

  task automatic model_reset();
    m_ir = 0; m_alu = 0; m_lmd = 0; m_link = 0; m_valid = 0;
    m_byp_valid = 0; m_byp_addr = 0; m_byp_data = 0; m_cnt = 0; m_cnt4 = 0;
  endtask

  function automatic void model_wb(input logic [31:0] ir, alu, lmd, link,
                                   output logic [4:0] dst, output logic [31:0] data);
    int op, fn, off, b, h;
    op = int'(ir[31:26]); fn = int'(ir[5:0]); off = int'(alu % 4);
    dst = 0; data = alu;
    if (op == 0) begin
      if (fn != 8) dst = ir[15:11];
      if (fn == 9) data = link;
    end else if (op == 3) begin
      dst = 31; data = link;
    end else if (op >= 8 && op <= 15) begin
      dst = ir[20:16];
    end else if (op == 32 || op == 33 || op == 35 || op == 36 || op == 37) begin
      dst = ir[20:16];
      b = int'((lmd >> (8 * (3 - off))) & 32'hFF);
      h = int'((lmd >> (16 * (1 - off / 2))) & 32'hFFFF);
      case (op)
        35: data = lmd;
        32: data = (b >= 128) ? 32'(b - 256) : 32'(b);
        36: data = 32'(b);
        33: data = (h >= 32768) ? 32'(h - 65536) : 32'(h);
        default: data = 32'(h);
      endcase
    end
  endfunction

  function automatic logic [31:0] rtype(input int rs, rt, rd, fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, rs, rt, imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // One cycle: drive at negedge, compare outputs against model, advance model at posedge.
  task automatic step(input logic [31:0] ir, input logic v, input logic [31:0] alu, lmd, link,
                      input logic stall, flush);
    logic [4:0]  dst;
    logic [31:0] data;
    logic        we;
    @(negedge CLK);
    MEM_IR = ir; MEM_valid = v; MEM_ALUout = alu; MEM_LMD = lmd; MEM_link = link;
    WB_stall = stall; WB_flush = flush;
    #1;
    model_wb(m_ir, m_alu, m_lmd, m_link, dst, data);
    we = m_valid && !stall && (dst != 0);
    check("wb_ir", WB_IR, m_ir);
    check("wb_valid", WB_valid, m_valid);
    check("rf_we", RF_we, we);
    check("rf_waddr", RF_waddr, dst);
    if (m_valid) check("rf_wdata", RF_wdata, data);
    check("byp_valid", BYP_valid, m_byp_valid);
    check("byp_addr", BYP_addr, m_byp_addr);
    check("byp_data", BYP_data, m_byp_data);
    check("retire_cnt", RETIRE_CNT, m_cnt);
    check("retire_cnt4", s_RETIRE_CNT, m_cnt4);
    @(posedge CLK);
    m_byp_valid = we;
    if (we) begin m_byp_addr = dst; m_byp_data = data; end
    if (m_valid && !stall) begin
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (flush) begin
      m_ir = 0; m_valid = 0;
    end else if (!stall) begin
      m_ir = ir; m_valid = v; m_alu = alu; m_lmd = lmd; m_link = link;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    longint snap;
    logic [31:0] ir;
    int kind;
    int fns[7]  = '{32, 34, 36, 37, 8, 9, 0};
    int lds[5]  = '{32, 33, 35, 36, 37};
    int sts[3]  = '{40, 41, 43};

    reset = 1; MEM_IR = 0; MEM_valid = 0; MEM_ALUout = 0; MEM_LMD = 0; MEM_link = 0;
    WB_stall = 0; WB_flush = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_wb_valid", WB_valid, 0);
    check("rst_wb_ir", WB_IR, 0);
    check("rst_rf_we", RF_we, 0);
    check("rst_byp_valid", BYP_valid, 0);
    check("rst_retire", RETIRE_CNT, 0);
    @(negedge CLK) reset = 0;

    step(rtype(1, 2, 3, 32), 1, 32'h1234, 0, 0, 0, 0);
    #1 check("add_we", RF_we, 1); check("add_waddr", RF_waddr, 3); check("add_wdata", RF_wdata, 32'h1234);
    step(itype(32, 1, 5, 0), 1, 32'h1, 32'h12F45678, 0, 0, 0);
    #1 check("add_byp_valid", BYP_valid, 1); check("add_byp_addr", BYP_addr, 3);
    check("add_byp_data", BYP_data, 32'h1234);
    check("lb_waddr", RF_waddr, 5); check("lb_wdata", RF_wdata, 32'hFFFFFFF4);
    step(itype(36, 1, 5, 0), 1, 32'h1, 32'h12F45678, 0, 0, 0);
    #1 check("lbu_wdata", RF_wdata, 32'h000000F4);
    step(itype(33, 1, 5, 0), 1, 32'h2, 32'h12F45678, 0, 0, 0);
    #1 check("lh_wdata", RF_wdata, 32'h00005678);
    step({6'd3, 26'h100}, 1, 32'h99, 0, 32'h400, 0, 0);
    #1 check("jal_waddr", RF_waddr, 31); check("jal_wdata", RF_wdata, 32'h400);
    step(rtype(4, 0, 7, 9), 1, 32'h77, 0, 32'h88, 0, 0);
    #1 check("jalr_waddr", RF_waddr, 7); check("jalr_wdata", RF_wdata, 32'h88);
    step(itype(8, 1, 0, 5), 1, 32'h5, 0, 0, 0, 0);
    snap = m_cnt;
    #1 check("addi_r0_we", RF_we, 0);
    step(itype(43, 1, 9, 0), 1, 32'h100, 0, 0, 0, 0);
    #1 check("sw_we", RF_we, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    #1 check("r0_sw_retire", RETIRE_CNT, snap + 2);

    step(rtype(1, 2, 4, 32), 1, 32'h44, 0, 0, 0, 0);
    #1 wr_count = 0;
    repeat (3) begin
      step(rtype(1, 2, 9, 32), 1, 32'h99, 0, 0, 1, 0);
      #1 check("stall_we", RF_we, 0);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    #1 check("stall_one_write", wr_count, 1);
    check("stall_byp_addr", BYP_addr, 4); check("stall_byp_data", BYP_data, 32'h44);

    step(rtype(1, 2, 6, 32), 1, 32'h66, 0, 0, 0, 0);
    step(rtype(1, 2, 9, 32), 1, 32'h99, 0, 0, 1, 1);
    #1 check("flush_valid", WB_valid, 0); check("flush_ir", WB_IR, 0);

    step(rtype(1, 2, 4, 32), 1, 32'h44, 0, 0, 0, 0);
    @(negedge CLK);
    WB_stall = 1; MEM_valid = 1;
    #2 reset = 1;
    #1 check("rstmid_we", RF_we, 0); check("rstmid_retire", RETIRE_CNT, 0);
    check("rstmid_byp_valid", BYP_valid, 0); check("rstmid_wb_valid", WB_valid, 0);
    model_reset();
    @(negedge CLK) reset = 0;

    repeat (21) step(itype(9, 1, 1, 1), 1, 32'h1, 0, 0, 0, 0);
    #1 check("sat_cnt4", s_RETIRE_CNT, 15); check("sat_cnt32", RETIRE_CNT, 20);

    repeat (400) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0: ir = rtype($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                      fns[$urandom_range(0, 6)]);
        1: ir = {6'd2, 26'($urandom)};
        2: ir = {6'd3, 26'($urandom)};
        3: ir = itype(4, $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
        4: ir = itype($urandom_range(8, 15), $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
        5, 6, 7: ir = itype(lds[$urandom_range(0, 4)], $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
        8: ir = itype(sts[$urandom_range(0, 2)], $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
        default: ir = $urandom;
      endcase
      step(ir, $urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
